// File: rtl/ws2812_rx.sv
// WS2812 line decoder: classifies high pulses by width, assembles GRB words, emits RGB + strobes.
// Latency: din edge to state action 2 cycles; last falling edge to rgb_valid 3 cycles.
// Backpressure: none, every strobe lasts one cycle. Optional forwarding via WS2812_RX_FWD_EN.
module ws2812_rx #(
    parameter int CLK_FRE      = 27_000_000,
    parameter int WS2812_WIDTH = 24,
    parameter int BIT_THRESH   = CLK_FRE / 1_000_000 * 625 / 1000,
    parameter int MAX_HIGH     = CLK_FRE / 1_000_000 * 15 / 10,
    parameter int RESET_CYCLES = CLK_FRE / 1_000_000 * 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] rgb_out,
    output logic        rgb_valid,
    output logic [8:0]  pixel_index,
    output logic        frame_end,
    output logic        err,
    output logic        dout
);
    localparam int BCW = $clog2(WS2812_WIDTH + 1);
    localparam logic [15:0]    THRESH_C = 16'(BIT_THRESH);
    localparam logic [15:0]    MAX_C    = 16'(MAX_HIGH);
    localparam logic [15:0]    RESET_C  = 16'(RESET_CYCLES);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WS2812_WIDTH - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, s_din_q, prev_q;
    logic [15:0]             cnt_q, cnt_d, cnt_inc;
    logic [WS2812_WIDTH-1:0] shift_q, shift_d, shift_new;
    logic [BCW-1:0]          bits_q, bits_d;
    logic [23:0]             rgb_q, rgb_d;
    logic                    valid_q, valid_d;
    logic [8:0]              idx_q, idx_d;
    logic                    fe_q, fe_d;
    logic                    err_q, err_d;
    logic                    rise, fall;

    assign rise      = s_din_q & ~prev_q;
    assign fall      = ~s_din_q & prev_q;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign shift_new = {shift_q[WS2812_WIDTH-2:0], (cnt_q >= THRESH_C)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        shift_d = shift_q;
        bits_d  = bits_q;
        rgb_d   = rgb_q;
        valid_d = 1'b0;
        idx_d   = idx_q;
        fe_d    = 1'b0;
        err_d   = 1'b0;
        // Index advances right after the strobe that displayed it, sticking at 511.
        if (valid_q && idx_q != 9'd511) begin
            idx_d = idx_q + 9'd1;
        end
        case (state_q)
            SYNC: begin
                if (s_din_q) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == RESET_C) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = 16'd1;
                end
            end
            HIGH: begin
                if (cnt_q > MAX_C) begin
                    err_d   = 1'b1;
                    state_d = SYNC;
                    cnt_d   = 16'd0;
                    shift_d = '0;
                    bits_d  = '0;
                    idx_d   = 9'd0;
                end else if (fall) begin
                    state_d = LOW;
                    cnt_d   = 16'd1;
                    shift_d = shift_new;
                    if (bits_q == LAST_BIT) begin
                        bits_d  = '0;
                        valid_d = 1'b1;
                        // Wire order is G,R,B; present as R,G,B.
                        rgb_d   = {shift_new[15:8], shift_new[23:16], shift_new[7:0]};
                    end else begin
                        bits_d = bits_q + BCW'(1);
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = 16'd1;
                end else if (cnt_q == RESET_C) begin
                    fe_d    = 1'b1;
                    err_d   = (bits_q != '0);
                    bits_d  = '0;
                    shift_d = '0;
                    idx_d   = 9'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            sync1_q <= 1'b0;
            s_din_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= 16'd0;
            shift_q <= '0;
            bits_q  <= '0;
            rgb_q   <= 24'd0;
            valid_q <= 1'b0;
            idx_q   <= 9'd0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= din;
            s_din_q <= sync1_q;
            prev_q  <= s_din_q;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    assign rgb_out     = rgb_q;
    assign rgb_valid   = valid_q;
    assign pixel_index = idx_q;
    assign frame_end   = fe_q;
    assign err         = err_q;

`ifdef WS2812_RX_FWD_EN
    logic fwd_q;
    logic dout_q;

    // Pixel 0 of each frame is consumed; everything after it is passed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            if (fe_d || err_d) begin
                fwd_q <= 1'b0;
            end else if (valid_q) begin
                fwd_q <= 1'b1;
            end
            dout_q <= fwd_q & s_din_q;
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

endmodule
